// File: rtl/scandoubler_pkg.sv
// Shared types and defaults for the scandoubler: RGB332 pixel layout,
// line-buffer geometry and output hsync width.
package scandoubler_pkg;

  localparam int SD_ADDR_W    = 9;
  localparam int SD_LINE_MAX  = 448;
  localparam int SD_HSYNC_LEN = 54;

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] r;
    logic [1:0] b;
  } rgb332_t;

  // Scanline dimming: each channel shifted right by one, MSB cleared.
  function automatic rgb332_t sd_halve(input rgb332_t p);
    rgb332_t o;
    o.g = p.g >> 1;
    o.r = p.r >> 1;
    o.b = p.b >> 1;
    return o;
  endfunction

endpackage

// File: rtl/scandoubler_line_buf.sv
// Two-bank ping-pong line store: simple dual-port RAM, one write port and
// one registered read port, no reset on contents.
module scandoubler_line_buf
  import scandoubler_pkg::*;
#(
  parameter int ADDR_W = SD_ADDR_W
) (
  input  logic            clk28,
  input  logic            we,
  input  logic [ADDR_W:0] waddr,
  input  rgb332_t         wdata,
  input  logic [ADDR_W:0] raddr,
  output rgb332_t         rdata
);

  rgb332_t mem_q [2**(ADDR_W+1)];
  rgb332_t rdata_q;

  always_ff @(posedge clk28) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scandoubler.sv
// 15 kHz -> 31 kHz scandoubler: each input line is stored and replayed twice
// at the 14 MHz pixel rate. Define SCANDOUBLER_SCANLINES_EN to dim the replay.
module scandoubler
  import scandoubler_pkg::*;
#(
  parameter int ADDR_W    = SD_ADDR_W,
  parameter int LINE_MAX  = SD_LINE_MAX,
  parameter int HSYNC_LEN = SD_HSYNC_LEN
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       ck7,
  input  logic       ck14,
  input  logic [2:0] r_in,
  input  logic [2:0] g_in,
  input  logic [1:0] b_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [2:0] r_out,
  output logic [2:0] g_out,
  output logic [1:0] b_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       odd_out
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LMAX = CW'(LINE_MAX);
  localparam logic [CW-1:0] HLEN = CW'(HSYNC_LEN);

  logic              hs_d_q;
  logic              wr_bank_q, wr_bank_d;
  logic [CW-1:0]     wr_x_q, wr_x_d;
  logic [CW-1:0]     line_len_q, line_len_d;
  logic [ADDR_W-1:0] rd_x_q, rd_x_d;
  logic              rd_pass_q, rd_pass_d;
  logic              rd_idle_q, rd_idle_d;
  logic              vs_lat_q, vs_lat_d;
  logic              s1_act_q, s1_act_d;
  logic              s1_hs_q, s1_hs_d;
  logic              s1_vs_q, s1_vs_d;
  logic              s1_odd_q, s1_odd_d;
  rgb332_t           rgb_q, rgb_d;
  logic              hsync_q, vsync_q, odd_q;

  logic              hs_rise;
  logic              we;
  rgb332_t           wdata, rdata, pix;

  assign hs_rise = hsync_in & ~hs_d_q;
  assign we      = ~hs_rise & ck7 & (wr_x_q < LMAX);
  assign wdata   = '{g: g_in, r: r_in, b: b_in};

  // Line start has priority over both pixel strobes.
  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_x_d     = wr_x_q;
    line_len_d = line_len_q;
    rd_x_d     = rd_x_q;
    rd_pass_d  = rd_pass_q;
    rd_idle_d  = rd_idle_q;
    vs_lat_d   = vs_lat_q;
    if (hs_rise) begin
      wr_bank_d  = ~wr_bank_q;
      line_len_d = (wr_x_q > LMAX) ? LMAX : wr_x_q;
      wr_x_d     = '0;
      rd_x_d     = '0;
      rd_pass_d  = 1'b0;
      rd_idle_d  = (line_len_d == '0);
      vs_lat_d   = vsync_in;
    end else begin
      if (we) wr_x_d = wr_x_q + CW'(1);
      if (ck14 && !rd_idle_q) begin
        if ({1'b0, rd_x_q} == line_len_q - CW'(1)) begin
          rd_x_d = '0;
          if (!rd_pass_q) rd_pass_d = 1'b1;
          else            rd_idle_d = 1'b1;
        end else begin
          rd_x_d = rd_x_q + ADDR_W'(1);
        end
      end
    end
  end

  scandoubler_line_buf #(.ADDR_W(ADDR_W)) u_line_buf (
    .clk28 (clk28),
    .we    (we),
    .waddr ({wr_bank_q, wr_x_q[ADDR_W-1:0]}),
    .wdata (wdata),
    .raddr ({~wr_bank_q, rd_x_q}),
    .rdata (rdata)
  );

  // Stage 1 tracks the RAM read latency so sync/flags line up with pixel data.
  always_comb begin
    s1_act_d = ~rd_idle_q;
    s1_hs_d  = ~rd_idle_q & ({1'b0, rd_x_q} < HLEN);
    s1_vs_d  = vs_lat_q;
    s1_odd_d = rd_pass_q;
    pix      = s1_act_q ? rdata : '0;
`ifdef SCANDOUBLER_SCANLINES_EN
    if (s1_odd_q) pix = sd_halve(pix);
`endif
    rgb_d    = pix;
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      hs_d_q     <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_x_q     <= '0;
      line_len_q <= '0;
      rd_x_q     <= '0;
      rd_pass_q  <= 1'b0;
      rd_idle_q  <= 1'b1;
      vs_lat_q   <= 1'b0;
      s1_act_q   <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_odd_q   <= 1'b0;
      rgb_q      <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      odd_q      <= 1'b0;
    end else begin
      hs_d_q     <= hsync_in;
      wr_bank_q  <= wr_bank_d;
      wr_x_q     <= wr_x_d;
      line_len_q <= line_len_d;
      rd_x_q     <= rd_x_d;
      rd_pass_q  <= rd_pass_d;
      rd_idle_q  <= rd_idle_d;
      vs_lat_q   <= vs_lat_d;
      s1_act_q   <= s1_act_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s1_odd_q   <= s1_odd_d;
      rgb_q      <= rgb_d;
      hsync_q    <= s1_hs_q;
      vsync_q    <= s1_vs_q;
      odd_q      <= s1_odd_q;
    end
  end

  assign r_out     = rgb_q.r;
  assign g_out     = rgb_q.g;
  assign b_out     = rgb_q.b;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;
  assign odd_out   = odd_q;

endmodule

// File: tb/tb_scandoubler.sv
// Scoreboard bench for the scandoubler: every ck14 pushes the pixel that read
// strobe should consume; a monitor pops and compares two clocks later.
module tb_scandoubler;

  logic       clk28 = 1'b0;
  logic       rst = 1'b1, ck7 = 1'b0, ck14 = 1'b0;
  logic       hsync_in = 1'b0, vsync_in = 1'b0;
  logic [2:0] r_in = '0, g_in = '0;
  logic [1:0] b_in = '0;
  logic [2:0] r_out, g_out;
  logic [1:0] b_out;
  logic       hsync_out, vsync_out, odd_out;

  always #5 clk28 = ~clk28;

  scandoubler dut (
    .clk28(clk28), .rst(rst), .ck7(ck7), .ck14(ck14),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .odd_out(odd_out)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit ck14_en = 1'b0;
  bit h_prev = 1'b0;

  // reference line store: wr_data fills during a line, rd_data is replayed
  logic [7:0]  wr_data [512];
  logic [7:0]  rd_data [512];
  int          wcnt = 0, m_len = 0, m_j = 0;
  bit          m_vs = 1'b0;
  logic [10:0] exp_q [$];
  bit          v_p1 = 1'b0, v_p2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] scan(input logic [7:0] p);
`ifdef SCANDOUBLER_SCANLINES_EN
    return {1'b0, p[7:6], 1'b0, p[4:3], 1'b0, p[1]};
`else
    return p;
`endif
  endfunction

  function automatic logic [7:0] pixval(input int mode, input int i);
    logic [7:0] v;
    case (mode)
      0:       v = i[7:0];
      1:       v = 8'(i * 3 + 7);
      2:       v = 8'hA5 ^ i[7:0];
      3:       v = 8'hFF;
      default: v = 8'(i + 8'h40);
    endcase
    return v;
  endfunction

  // {rgb[7:0], hsync, vsync, odd} that the current read strobe consumes
  function automatic logic [10:0] expect_now();
    logic [7:0] p = 8'h00;
    bit hs = 1'b0, odd = 1'b0;
    int x;
    if (m_len != 0) begin
      if (m_j < m_len) begin
        x = m_j; p = rd_data[x]; hs = (x < 54);
      end else if (m_j < 2 * m_len) begin
        x = m_j - m_len; p = scan(rd_data[x]); hs = (x < 54); odd = 1'b1;
      end else begin
        odd = 1'b1;
      end
    end
    return {p, hs, m_vs, odd};
  endfunction

  task automatic tick(input bit h, input bit p7, input logic [7:0] pix, input bit vs);
    bit c14;
    bit rise;
    c14  = ck14_en && cyc[0];
    rise = h && !h_prev;
    hsync_in = h; vsync_in = vs; ck7 = p7; ck14 = c14;
    {g_in, r_in, b_in} = pix;
    if (!rst) begin
      if (c14) exp_q.push_back(expect_now());
      if (rise) begin
        rd_data = wr_data;
        m_len = wcnt; m_j = 0; m_vs = vs; wcnt = 0;
      end else begin
        if (c14) m_j++;
        if (p7 && wcnt < 448) begin
          wr_data[wcnt] = pix; wcnt++;
        end
      end
    end
    h_prev = h;
    @(posedge clk28);
    #1;
    cyc++;
  endtask

  task automatic send_line(input int n, input int mode, input bit vs, input bit coincide, input bit pad);
    int i = 0;
    int lc = 0;
    int tgt = coincide ? 1 : 0;
    bit p;
    while ((cyc % 4) != tgt) tick(1'b0, 1'b0, 8'h00, vs);
    for (int k = 0; k < 4; k++) begin
      if (coincide && k == 0) tick(1'b1, 1'b1, 8'hEE, vs);
      else                    tick(1'b1, 1'b0, 8'h00, vs);
      lc++;
    end
    while (i < n) begin
      p = ((cyc % 4) == 1);
      tick(1'b0, p, pixval(mode, i), vs);
      if (p) i++;
      lc++;
    end
    if (pad) while (lc < 4 * m_len + 8) begin
      tick(1'b0, 1'b0, 8'h00, vs);
      lc++;
    end
  endtask

  task automatic do_reset();
    ck14_en = 1'b0;
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_outputs", {r_out, g_out, b_out, hsync_out, vsync_out, odd_out}, 32'h0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    m_len = 0; m_j = 0; m_vs = 1'b0; wcnt = 0;
    ck14_en = 1'b1;
  endtask

  always @(posedge clk28) begin
    v_p1 <= ck14 & ~rst;
    v_p2 <= v_p1;
  end

  always @(negedge clk28) begin
    if (v_p2) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow got=output want=none (cyc %0d)", cyc);
      end else begin
        check("pixel", {g_out, r_out, b_out, hsync_out, vsync_out, odd_out}, exp_q.pop_front());
      end
    end
  end

  initial begin
    do_reset();
    send_line(448, 0, 1'b0, 1'b0, 1'b1);   // first line after reset: nothing replayed
    send_line(448, 0, 1'b0, 1'b0, 1'b1);   // replays 0..255,0..191 twice
    send_line(100, 1, 1'b0, 1'b0, 1'b1);
    send_line(500, 2, 1'b0, 1'b0, 1'b1);   // replays the 100-pixel line then idles
    send_line(10, 1, 1'b0, 1'b1, 1'b1);    // hs_rise on a ck7; replays saturated 448
    send_line(20, 4, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) send_line(20, 4, 1'b1, 1'b0, 1'b1);
    send_line(20, 4, 1'b0, 1'b0, 1'b1);
    send_line(20, 4, 1'b0, 1'b0, 1'b1);
    send_line(60, 3, 1'b0, 1'b0, 1'b1);
    send_line(30, 4, 1'b0, 1'b0, 1'b1);    // replays the 8'hFF line
    send_line(5, 1, 1'b0, 1'b0, 1'b0);     // cuts the 30-pixel replay short
    send_line(8, 2, 1'b0, 1'b0, 1'b1);
    send_line(60, 0, 1'b0, 1'b0, 1'b1);
    send_line(10, 1, 1'b0, 1'b0, 1'b0);    // reset lands mid-replay
    do_reset();
    send_line(20, 0, 1'b0, 1'b0, 1'b1);    // no output yet
    send_line(20, 1, 1'b0, 1'b0, 1'b1);
    send_line(4, 0, 1'b0, 1'b0, 1'b1);
    ck14_en = 1'b0;
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 8'h00, 1'b0);
    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
